// File: rtl/game_flow_sequencer_pkg.sv
// Shared game-flow types for Bumpy: the state encoding seen by the drawers and the
// message-screen mux, plus a width helper for the level index.
package game_flow_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        LEVEL_WON = 3'd2,
        LIFE_LOST = 3'd3,
        GAME_WON  = 3'd4,
        GAME_OVER = 3'd5
    } game_state_t;

    // Keeps the level bus at least one bit wide for single-level builds.
    function automatic int unsigned level_width(input int unsigned num_levels);
        return (num_levels > 1) ? $clog2(num_levels) : 1;
    endfunction

endpackage

// File: rtl/game_flow_sequencer_if.sv
// Bundle between the game-flow sequencer (slave) and the rest of the game (master):
// per-pixel event flags and frame/key inputs in, state and counters out.
interface game_flow_sequencer_if #(
    parameter int unsigned NUM_LEVELS = 4
) ();
    import game_flow_pkg::*;

    localparam int unsigned LevelW = level_width(NUM_LEVELS);

    logic              startOfFrame;
    logic              start_key;
    logic              victory;
    logic              Loss;
    logic              Remove_Gift;
    game_state_t       game_state;
    logic [LevelW-1:0] level;
    logic [1:0]        lives;
    logic [2:0]        gifts_left;
    logic              gift_clear;
    logic              level_load;
    logic              freeze;

    modport master (
        output startOfFrame, start_key, victory, Loss, Remove_Gift,
        input  game_state, level, lives, gifts_left, gift_clear, level_load, freeze
    );

    modport slave (
        input  startOfFrame, start_key, victory, Loss, Remove_Gift,
        output game_state, level, lives, gifts_left, gift_clear, level_load, freeze
    );

endinterface

// File: rtl/game_flow_sequencer_frame_event_latch.sv
// Remembers that a pixel-level event occurred during the current frame; the flag is
// handed over at startOfFrame, and an input seen on that very cycle belongs to the next frame.
module frame_event_latch (
    input  logic clk,
    input  logic resetN,
    input  logic i_sof,
    input  logic i_clr,
    input  logic i_in,
    output logic o_flag
);

    logic r_flag;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_flag <= 1'b0;
        end else if (i_clr) begin
            r_flag <= 1'b0;
        end else if (i_sof) begin
            r_flag <= i_in;
        end else begin
            r_flag <= r_flag | i_in;
        end
    end

    assign o_flag = r_flag;

endmodule

// File: rtl/game_flow_sequencer.sv
// Bumpy game-flow FSM: turns per-frame collision events into play / message / end states
// and owns the level, lives and remaining-gift counters.
module game_flow_sequencer
    import game_flow_pkg::*;
#(
    parameter int unsigned NUM_LEVELS      = 4,
    parameter int unsigned LIVES_INIT      = 3,
    parameter int unsigned GIFTS_PER_LEVEL = 4,
    parameter int unsigned MSG_FRAMES      = 60
) (
    input logic                  clk,
    input logic                  resetN,
    game_flow_sequencer_if.slave io_bus
);

    localparam int unsigned LevelW = level_width(NUM_LEVELS);
    localparam int unsigned MsgW   = $clog2(MSG_FRAMES + 1);

    localparam logic [2:0] S_IDLE      = IDLE;
    localparam logic [2:0] S_PLAY      = PLAY;
    localparam logic [2:0] S_LEVEL_WON = LEVEL_WON;
    localparam logic [2:0] S_LIFE_LOST = LIFE_LOST;
    localparam logic [2:0] S_GAME_WON  = GAME_WON;
    localparam logic [2:0] S_GAME_OVER = GAME_OVER;

    localparam logic [1:0]        LivesInit = 2'(LIVES_INIT);
    localparam logic [2:0]        GiftsInit = 3'(GIFTS_PER_LEVEL);
    localparam logic [LevelW-1:0] LastLevel = LevelW'(NUM_LEVELS - 1);
    localparam logic [LevelW-1:0] LevelOne  = LevelW'(1);
    localparam logic [MsgW-1:0]   MsgLast   = MsgW'(MSG_FRAMES - 1);
    localparam logic [MsgW-1:0]   MsgOne    = MsgW'(1);

    logic [2:0]        r_state, w_state_d;
    logic [LevelW-1:0] r_level, w_level_d;
    logic [1:0]        r_lives, w_lives_d;
    logic [2:0]        r_gifts, w_gifts_d;
    logic [MsgW-1:0]   r_msg,   w_msg_d;
    logic              r_load;
    logic              r_key;

    logic w_key_rise;
    logic w_enter_play;
    logic w_loss_seen, w_vic_seen, w_gift_seen;

    assign w_key_rise   = io_bus.start_key & ~r_key;
    assign w_enter_play = (w_state_d == S_PLAY) && (r_state != S_PLAY);

    frame_event_latch u_loss_latch (
        .clk    (clk),
        .resetN (resetN),
        .i_sof  (io_bus.startOfFrame),
        .i_clr  (w_enter_play),
        .i_in   (io_bus.Loss),
        .o_flag (w_loss_seen)
    );

    frame_event_latch u_vic_latch (
        .clk    (clk),
        .resetN (resetN),
        .i_sof  (io_bus.startOfFrame),
        .i_clr  (w_enter_play),
        .i_in   (io_bus.victory),
        .o_flag (w_vic_seen)
    );

    frame_event_latch u_gift_latch (
        .clk    (clk),
        .resetN (resetN),
        .i_sof  (io_bus.startOfFrame),
        .i_clr  (w_enter_play),
        .i_in   (io_bus.Remove_Gift),
        .o_flag (w_gift_seen)
    );

    always_comb begin
        w_state_d = r_state;
        w_level_d = r_level;
        w_lives_d = r_lives;
        w_gifts_d = r_gifts;
        w_msg_d   = r_msg;
        case (r_state)
            S_IDLE: begin
                if (w_key_rise) begin
                    w_level_d = '0;
                    w_lives_d = LivesInit;
                    w_gifts_d = GiftsInit;
                    w_state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                // One event per frame, Loss first; a victory before the hole opens falls
                // through so a gift seen in the same frame still counts.
                if (io_bus.startOfFrame) begin
                    if (w_loss_seen) begin
                        if (r_lives <= 2'd1) begin
                            w_lives_d = 2'd0;
                            w_state_d = S_GAME_OVER;
                        end else begin
                            w_lives_d = r_lives - 2'd1;
                            w_state_d = S_LIFE_LOST;
                        end
                    end else if (w_vic_seen && (r_gifts == 3'd0)) begin
                        w_state_d = (r_level == LastLevel) ? S_GAME_WON : S_LEVEL_WON;
                    end else if (w_gift_seen && (r_gifts != 3'd0)) begin
                        w_gifts_d = r_gifts - 3'd1;
                    end
                end
            end
            S_LEVEL_WON, S_LIFE_LOST: begin
                if (io_bus.startOfFrame) begin
                    if (r_msg == MsgLast) begin
                        w_msg_d   = '0;
                        w_gifts_d = GiftsInit;
                        w_state_d = S_PLAY;
                        if (r_state == S_LEVEL_WON) begin
                            w_level_d = r_level + LevelOne;
                        end
                    end else begin
                        w_msg_d = r_msg + MsgOne;
                    end
                end
            end
            S_GAME_WON, S_GAME_OVER: begin
                if (w_key_rise) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state <= S_IDLE;
            r_level <= '0;
            r_lives <= LivesInit;
            r_gifts <= GiftsInit;
            r_msg   <= '0;
            r_load  <= 1'b0;
            r_key   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_level <= w_level_d;
            r_lives <= w_lives_d;
            r_gifts <= w_gifts_d;
            r_msg   <= w_msg_d;
            r_load  <= w_enter_play;
            r_key   <= io_bus.start_key;
        end
    end

    assign io_bus.game_state = game_state_t'(r_state);
    assign io_bus.level      = r_level;
    assign io_bus.lives      = r_lives;
    assign io_bus.gifts_left = r_gifts;
    assign io_bus.gift_clear = (r_gifts == 3'd0);
    assign io_bus.level_load = r_load;
    assign io_bus.freeze     = (r_state != S_PLAY);

endmodule
